tmds_encoder: RTL and testbench
===============================

// Module: tmds_encoder
// PURPOSE
//  Three-channel DVI/TMDS 8b/10b encoder in the pixclk domain, directly upstream of the 10:1 serializer.
//  Takes 24-bit RGB, hsync/vsync and video-enable from the video timing/pixel generator.
//  Emits 10-bit symbols TMDS_red/TMDS_green/TMDS_blue, LSB transmitted first.
//  Each channel does transition minimisation, running-disparity DC balance and control-code insertion during blanking.
// PARAMETERS
//  DISP_W   5      signed width of each channel's running-disparity counter (range -16..+15)
//  CTRL_RG  2'b00  {C1,C0} sent on the red and green channels during blanking
// PORTS
//  pixclk      in   1   pixel clock (40 MHz); the only clock
//  rst_n       in   1   synchronous, active-low reset
//  de          in   1   video data enable; 1 = active pixel
//  hsync       in   1   horizontal sync; sent on blue C0
//  vsync       in   1   vertical sync; sent on blue C1
//  red         in   8   pixel red byte
//  green       in   8   pixel green byte
//  blue        in   8   pixel blue byte
//  TMDS_red    out  10  encoded red symbol to the serializer
//  TMDS_green  out  10  encoded green symbol to the serializer
//  TMDS_blue   out  10  encoded blue symbol to the serializer
//  (TMDS_ENC_PATTERN_EN only) test_pat  in  1  1 = replace pixel bytes with the internal test pattern
// BEHAVIOUR
//  Reset (rst_n=0 at a pixclk edge)
//   - All pipeline registers clear; disparity counters go to 0.
//   - Every TMDS_* output is 10'b1101010100 (control code 00).
//  Pipeline
//   - Two-stage, fixed latency of 2 pixclk cycles from inputs to TMDS_*; no stalls, no handshake.
//   - de, hsync and vsync are delayed alongside the data.
//  Stage 1 (per channel, byte D)
//   - N1 = popcount(D).
//   - XNOR path if N1>4 or (N1==4 and D[0]==0):
//     q_m[0]=D[0]; q_m[i]=~(q_m[i-1]^D[i]); q_m[8]=0.
//   - Otherwise XOR path: q_m[i]=q_m[i-1]^D[i]; q_m[8]=1.
//   - q_m, de and the control bits are registered.
//  Stage 2 (n1/n0 = ones/zeros in q_m[7:0]; cnt = running disparity)
//   - If cnt==0 or n1==n0:
//     out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
//     cnt += q_m[8] ? n1-n0 : n0-n1.
//   - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
//     out = {1, q_m[8], ~q_m[7:0]};
//     cnt += 2*q_m[8] + n0-n1.
//   - Else:
//     out = {0, q_m[8], q_m[7:0]};
//     cnt += n1-n0 - 2*~q_m[8].
//   - Arithmetic is signed DISP_W bits. |cnt| never exceeds 8 in legal operation, so there is no saturation.
//  Blanking (delayed de=0)
//   - Control code by {C1,C0}: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
//   - Blue channel uses {vsync,hsync}; red and green use CTRL_RG.
//   - cnt is forced to 0 on every blanking cycle.
//  Edge cases
//   - de toggling every cycle: each active symbol is encoded from cnt=0.
//   - Reset mid-line: outputs show control code 00 on the next edge; encoding restarts with cnt=0.
// CONFIGURATION
//  TMDS_ENC_PATTERN_EN defined
//   - Adds the test_pat port and a column/row counter pair (12 bits each).
//   - Column counter: increments on de, clears on the cycle after de falls.
//   - Row counter: increments on each falling edge of de, clears on the rising edge of vsync.
//   - While test_pat=1, pixel bytes become red=col[7:0], green=row[7:0], blue=8'h80.
//   - Counters clear on reset. Latency is unchanged.
//  TMDS_ENC_PATTERN_EN undefined
//   - No test_pat port and no counters; pixel bytes pass straight to stage 1.
// STRUCTURE
//  Package tmds_pkg holds:
//   - The four control-code constants.
//   - The symbol typedef (logic [9:0]).
//   - The disparity typedef (signed [DISP_W-1:0]).
//   - A popcount8 function.
//  Sub-module tmds_channel_enc: one channel's stage 1, stage 2 and disparity counter, instantiated three times.
//  The top level holds sync/control routing, the control delay line and the optional pattern generator.
// TESTING
//  1. Reset held, then released with de=0, sync=00 -> all TMDS_* = 10'b1101010100 throughout.
//  2. de=1, blue=8'h00 for two cycles from cnt=0 -> blue symbols 10'h100, then 10'h3FF; cnt goes -8, then +2.
//  3. de=1, blue=8'hFF from cnt=0 -> 10'h200, cnt=-8 (XNOR path).
//  4. de=0 with {vsync,hsync} stepped 00, 01, 10, 11 -> TMDS_blue shows the four control codes 2 cycles later;
//     red and green stay 10'b1101010100.
//  5. Random active bytes over 10k cycles, checked against a reference model -> exact match;
//     after decoding, |cnt|<=8 and each 10-bit symbol has at most 5 transitions.
//  6. (TMDS_ENC_PATTERN_EN) test_pat=1 over 3 lines of 4 pixels -> red ramps 0..3;
//     green reads 0, 1, 2 per line; blue is constant 8'h80.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS types, control-code constants and bit-count helper.
// Combinational only; no latency, no flow control.
// Imported by the encoder top, its channel sub-module and the port interface.
package tmds_pkg;

    localparam int TMDS_DISP_W = 5;

    typedef logic [9:0] sym_t;
    typedef logic signed [TMDS_DISP_W-1:0] disp_t;

    localparam sym_t CTRL_00 = 10'b1101010100;
    localparam sym_t CTRL_01 = 10'b0010101011;
    localparam sym_t CTRL_10 = 10'b0101010100;
    localparam sym_t CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    function automatic sym_t ctrl_code(input logic [1:0] c);
        sym_t s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Video-timing side and serializer side of the TMDS encoder in one bundle.
// No latency of its own; no backpressure (pixel-rate streaming).
// test_pat exists only when TMDS_ENC_PATTERN_EN is defined.
interface tmds_encoder_if;
    logic               de;
    logic               hsync;
    logic               vsync;
    logic [7:0]         red;
    logic [7:0]         green;
    logic [7:0]         blue;
`ifdef TMDS_ENC_PATTERN_EN
    logic               test_pat;
`endif
    tmds_pkg::sym_t     TMDS_red;
    tmds_pkg::sym_t     TMDS_green;
    tmds_pkg::sym_t     TMDS_blue;

`ifdef TMDS_ENC_PATTERN_EN
    modport master (output de, hsync, vsync, red, green, blue, test_pat,
                    input  TMDS_red, TMDS_green, TMDS_blue);
    modport slave  (input  de, hsync, vsync, red, green, blue, test_pat,
                    output TMDS_red, TMDS_green, TMDS_blue);
`else
    modport master (output de, hsync, vsync, red, green, blue,
                    input  TMDS_red, TMDS_green, TMDS_blue);
    modport slave  (input  de, hsync, vsync, red, green, blue,
                    output TMDS_red, TMDS_green, TMDS_blue);
`endif
endinterface

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: transition minimisation, DC balance, control-code insertion.
// Latency 2 pixclk (q_m register, then symbol register); never stalls.
// de_s1/ctrl_s1 arrive already delayed one cycle by the top level.
module tmds_channel_enc
    import tmds_pkg::*;
#(
    parameter int DISP_W = TMDS_DISP_W
) (
    input  logic       pixclk,
    input  logic       rst_n,
    input  logic [7:0] d,
    input  logic       de_s1,
    input  logic [1:0] ctrl_s1,
    output sym_t       sym
);

    localparam logic signed [DISP_W-1:0] DISP_ZERO = '0;
    localparam logic signed [DISP_W-1:0] DISP_TWO  = DISP_W'(2);

    logic [3:0] n1_d;
    logic       use_xnor;
    logic [8:0] q_m_c;
    logic [8:0] q_m;

    always_comb begin
        logic b;
        n1_d     = popcount8(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
        q_m_c    = '0;
        b        = d[0];
        q_m_c[0] = b;
        for (int i = 1; i < 8; i++) begin
            b        = use_xnor ? ~(b ^ d[i]) : (b ^ d[i]);
            q_m_c[i] = b;
        end
        q_m_c[8] = ~use_xnor;
    end

    always_ff @(posedge pixclk) begin
        if (!rst_n) q_m <= '0;
        else        q_m <= q_m_c;
    end

    logic [3:0]               n1_q;
    logic [3:0]               n0_q;
    logic signed [DISP_W-1:0] diff;
    logic signed [DISP_W-1:0] cnt;
    logic signed [DISP_W-1:0] cnt_nx;
    sym_t                     sym_nx;

    always_comb begin
        n1_q   = popcount8(q_m[7:0]);
        n0_q   = 4'd8 - n1_q;
        diff   = DISP_W'($signed({1'b0, n1_q})) - DISP_W'($signed({1'b0, n0_q}));
        sym_nx = ctrl_code(ctrl_s1);
        cnt_nx = DISP_ZERO;
        if (de_s1) begin
            if ((cnt == DISP_ZERO) || (n1_q == n0_q)) begin
                sym_nx = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                cnt_nx = q_m[8] ? (cnt + diff) : (cnt - diff);
            end else if (((cnt > DISP_ZERO) && (n1_q > n0_q)) ||
                         ((cnt < DISP_ZERO) && (n0_q > n1_q))) begin
                // Invert to pull the running disparity back towards zero.
                sym_nx = {1'b1, q_m[8], ~q_m[7:0]};
                cnt_nx = cnt + (q_m[8] ? DISP_TWO : DISP_ZERO) - diff;
            end else begin
                sym_nx = {1'b0, q_m[8], q_m[7:0]};
                cnt_nx = cnt + diff - (q_m[8] ? DISP_ZERO : DISP_TWO);
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            sym <= CTRL_00;
            cnt <= DISP_ZERO;
        end else begin
            sym <= sym_nx;
            cnt <= cnt_nx;
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// Three-channel DVI/TMDS encoder; optional test pattern via TMDS_ENC_PATTERN_EN.
// Latency 2 pixclk from inputs to TMDS_*; streaming, no stalls or handshake.
// Blue carries {vsync,hsync} in blanking, red/green carry CTRL_RG.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int         DISP_W  = TMDS_DISP_W,
    parameter logic [1:0] CTRL_RG = 2'b00
) (
    input  logic          pixclk,
    input  logic          rst_n,
    tmds_encoder_if.slave vid
);

    logic       de_s1;
    logic       hsync_s1;
    logic       vsync_s1;
    logic [7:0] red_px;
    logic [7:0] green_px;
    logic [7:0] blue_px;

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            de_s1    <= 1'b0;
            hsync_s1 <= 1'b0;
            vsync_s1 <= 1'b0;
        end else begin
            de_s1    <= vid.de;
            hsync_s1 <= vid.hsync;
            vsync_s1 <= vid.vsync;
        end
    end

`ifdef TMDS_ENC_PATTERN_EN
    logic [11:0] col;
    logic [11:0] row;
    logic        vsync_q;

    // de_s1 doubles as the previous-cycle de for falling-edge detection.
    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            vsync_q <= 1'b0;
        end else begin
            col     <= vid.de ? (col + 12'd1) : '0;
            vsync_q <= vid.vsync;
            if (vid.vsync && !vsync_q)  row <= '0;
            else if (de_s1 && !vid.de)  row <= row + 12'd1;
        end
    end

    always_comb begin
        red_px   = vid.red;
        green_px = vid.green;
        blue_px  = vid.blue;
        if (vid.test_pat) begin
            red_px   = col[7:0];
            green_px = row[7:0];
            blue_px  = 8'h80;
        end
    end
`else
    assign red_px   = vid.red;
    assign green_px = vid.green;
    assign blue_px  = vid.blue;
`endif

    sym_t sym_red;
    sym_t sym_green;
    sym_t sym_blue;

    tmds_channel_enc #(.DISP_W(DISP_W)) u_enc_red (
        .pixclk  (pixclk),
        .rst_n   (rst_n),
        .d       (red_px),
        .de_s1   (de_s1),
        .ctrl_s1 (CTRL_RG),
        .sym     (sym_red)
    );

    tmds_channel_enc #(.DISP_W(DISP_W)) u_enc_green (
        .pixclk  (pixclk),
        .rst_n   (rst_n),
        .d       (green_px),
        .de_s1   (de_s1),
        .ctrl_s1 (CTRL_RG),
        .sym     (sym_green)
    );

    tmds_channel_enc #(.DISP_W(DISP_W)) u_enc_blue (
        .pixclk  (pixclk),
        .rst_n   (rst_n),
        .d       (blue_px),
        .de_s1   (de_s1),
        .ctrl_s1 ({vsync_s1, hsync_s1}),
        .sym     (sym_blue)
    );

    assign vid.TMDS_red   = sym_red;
    assign vid.TMDS_green = sym_green;
    assign vid.TMDS_blue  = sym_blue;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and randomized bench for tmds_encoder with an independent encoding model.
module tb_tmds_encoder;

    logic pixclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 pixclk = ~pixclk;

    tmds_encoder_if vif ();

    tmds_encoder #(.DISP_W(5), .CTRL_RG(2'b00)) dut (
        .pixclk (pixclk),
        .rst_n  (rst_n),
        .vid    (vif)
    );

    typedef struct {
        bit         vld;
        bit         act;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } exp_t;

    localparam logic [9:0] C00 = 10'b1101010100;

    int    n_cmp = 0;
    int    n_mis = 0;
    int    mcnt [3];
    int    rd   [3];
    string phase = "reset";
    exp_t  p0, p1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [9:0] exp_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] ref_enc(input logic [7:0] d, input int cin, output int cout);
        int n, n1, n0, q8;
        bit xn;
        logic [8:0] q;
        logic [9:0] s;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        xn = (n > 4) || (n == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        q8 = xn ? 0 : 1;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(q[i]);
        n0 = 8 - n1;
        if (cin == 0 || n1 == n0) begin
            s    = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cout = cin + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
        end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
            s    = {1'b1, q[8], ~q[7:0]};
            cout = cin + 2 * q8 + n0 - n1;
        end else begin
            s    = {1'b0, q[8], q[7:0]};
            cout = cin + n1 - n0 - 2 * (1 - q8);
        end
        return s;
    endfunction

    function automatic int ones10(input logic [9:0] s);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(s[i]);
        return n;
    endfunction

    function automatic int trans10(input logic [9:0] s);
        int n = 0;
        for (int i = 0; i < 9; i++) if (s[i] != s[i+1]) n++;
        return n;
    endfunction

    // One pixel slot: check the symbols due now, then apply the next inputs.
    task automatic tick(input logic rst, input logic de, input logic hs, input logic vs,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb);
        logic [9:0] s [3];
        @(negedge pixclk);
        if (p1.vld) begin
            check("red",   16'(vif.TMDS_red),   16'(p1.r));
            check("green", 16'(vif.TMDS_green), 16'(p1.g));
            check("blue",  16'(vif.TMDS_blue),  16'(p1.b));
            s[0] = vif.TMDS_red;
            s[1] = vif.TMDS_green;
            s[2] = vif.TMDS_blue;
            for (int k = 0; k < 3; k++) begin
                if (p1.act) begin
                    rd[k] += 2 * ones10(s[k]) - 10;
                    check("disp_bound", 16'(rd[k] <= 8 && rd[k] >= -8), 16'd1);
                    check("trans_max5", 16'(trans10(s[k]) <= 5), 16'd1);
                end else begin
                    rd[k] = 0;
                end
            end
        end
        p1 = p0;
        rst_n     = rst;
        vif.de    = de;
        vif.hsync = hs;
        vif.vsync = vs;
        vif.red   = r;
        vif.green = g;
        vif.blue  = b;
        if (!rst) begin
            p0   = '{1'b1, 1'b0, C00, C00, C00};
            p1   = p0;
            mcnt = '{0, 0, 0};
        end else begin
            p0 = '{1'b1, de, er, eg, eb};
        end
    endtask

    task automatic drive2(input logic de, input logic hs, input logic vs,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [7:0] mr, input logic [7:0] mg, input logic [7:0] mb);
        logic [9:0] er, eg, eb;
        int c;
        if (de) begin
            er = ref_enc(mr, mcnt[0], c); mcnt[0] = c;
            eg = ref_enc(mg, mcnt[1], c); mcnt[1] = c;
            eb = ref_enc(mb, mcnt[2], c); mcnt[2] = c;
        end else begin
            er   = exp_ctrl(2'b00);
            eg   = exp_ctrl(2'b00);
            eb   = exp_ctrl({vs, hs});
            mcnt = '{0, 0, 0};
        end
        tick(1'b1, de, hs, vs, r, g, b, er, eg, eb);
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        drive2(de, hs, vs, r, g, b, r, g, b);
    endtask

    initial begin
        vif.de = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0;
        vif.red = '0; vif.green = '0; vif.blue = '0;
`ifdef TMDS_ENC_PATTERN_EN
        vif.test_pat = 1'b0;
`endif
        p0 = '{1'b1, 1'b0, C00, C00, C00};
        p1 = p0;
        mcnt = '{0, 0, 0};
        rd   = '{0, 0, 0};

        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C00);
        phase = "idle";
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C00);

        phase = "zeros";
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C00);

        phase = "mix";
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h55, 8'hFF, 10'h1FF, 10'h133, 10'h200);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C00);

        phase = "toggle";
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C00);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);

        phase = "ctrl";
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, 10'b1101010100);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, 10'b0010101011);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, C00, C00, 10'b0101010100);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, C00, C00, 10'b1010101011);

        phase = "midrst";
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hF0, 8'h3C);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hF0, 8'h3C);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, C00, C00, C00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h55);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        phase = "random";
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom), 8'($urandom));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

`ifdef TMDS_ENC_PATTERN_EN
        phase = "pattern";
        vif.test_pat = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int ln = 0; ln < 3; ln++) begin
            for (int px = 0; px < 4; px++) begin
                drive2(1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hC3, 8'(px), 8'(ln), 8'h80);
            end
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        end
        vif.test_pat = 1'b0;
`endif

        phase = "flush";
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
